bram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port BRAM (1-cycle read latency, 32-bit, byte write enables) between N_MASTERS read/write engines. Each engine requests the port, holds it for a whole burst, and releases it by dropping its request. A hold limit can preempt long bursts. The block sits between the engines and the BRAM controller port (en/we/addr/din/dout/rst).

---
 rtl/bram_port_arbiter_if.sv | 27 ++
 rtl/bram_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_bram_port_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// Engine-side bus of the BRAM port arbiter: per-master request and port
// signals going in, registered grants and the shared read return coming out.
interface bram_port_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int AW        = 32
);
  logic [N_MASTERS-1:0]    m_req;
  logic [N_MASTERS-1:0]    m_gnt;
  logic [N_MASTERS-1:0]    m_en;
  logic [4*N_MASTERS-1:0]  m_we;
  logic [AW*N_MASTERS-1:0] m_addr;
  logic [32*N_MASTERS-1:0] m_wdata;
  logic [31:0]             m_rdata;
  logic [N_MASTERS-1:0]    m_rvalid;

  // Engines drive requests and port signals, receive grant and read data.
  modport master (
    output m_req, m_en, m_we, m_addr, m_wdata,
    input  m_gnt, m_rdata, m_rvalid
  );

  // Arbiter side of the same bus.
  modport slave (
    input  m_req, m_en, m_we, m_addr, m_wdata,
    output m_gnt, m_rdata, m_rvalid
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM (1-cycle read latency)
// between N_MASTERS engines. An engine owns the port for a whole burst and
// releases it by dropping its request; MAX_HOLD optionally preempts long
// bursts when someone else is waiting.
module bram_port_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int AW        = 32,
  parameter int MAX_HOLD  = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  bram_port_arbiter_if.slave  m,
  output logic                bram_en,
  output logic [3:0]          bram_we,
  output logic [AW-1:0]       bram_addr,
  output logic [31:0]         bram_wdata,
  input  logic [31:0]         bram_rdata,
  output logic                bram_rst,
  output logic                busy,
  output logic [1:0]          owner
);
  localparam int IW = (N_MASTERS > 2) ? 2 : 1;
  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t               state;
  logic [N_MASTERS-1:0] gnt;
  logic [N_MASTERS-1:0] win_oh;
  logic [N_MASTERS-1:0] rvalid;
  logic [IW-1:0]        own_idx;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        rd_owner;
  logic [HW-1:0]        hold_cnt;
  logic                 own_req;
  logic                 others_req;
  logic                 preempt;
  logic                 q;
  logic                 rd_d1;

  // Lowest index after ptr (wrapping) among the requesters; ptr itself last.
  function automatic logic [IW-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    int            d;
    int            best_d;
    pick   = ptr;
    best_d = N_MASTERS;
    for (int i = 0; i < N_MASTERS; i++) begin
      d = (i + N_MASTERS - 1 - int'(ptr)) % N_MASTERS;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        pick   = IW'(i);
      end
    end
    return pick;
  endfunction

  assign win_idx = rr_pick(m.m_req, rr_ptr);
  assign preempt = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && others_req;
  assign q       = (state == OWN) && own_req;

  // Split the request vector into the owner's request and everyone else's.
  always_comb begin
    own_req    = 1'b0;
    others_req = 1'b0;
    win_oh     = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (own_idx == IW'(i)) own_req = m.m_req[i];
      else if (m.m_req[i])   others_req = 1'b1;
      if (win_idx == IW'(i)) win_oh[i] = 1'b1;
    end
  end

  // Ownership FSM: grant in IDLE, release or preempt in OWN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      own_idx  <= '0;
      rr_ptr   <= IW'(N_MASTERS - 1);
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|m.m_req) begin
            gnt      <= win_oh;
            own_idx  <= win_idx;
            hold_cnt <= '0;
            state    <= OWN;
          end
        end
        OWN: begin
          if (!own_req || preempt) begin
            gnt    <= '0;
            rr_ptr <= own_idx;
            state  <= IDLE;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Port mux: only the owner reaches the BRAM, and only while it still requests.
  always_comb begin
    bram_en    = 1'b0;
    bram_we    = 4'h0;
    bram_addr  = '0;
    bram_wdata = 32'h0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (q && (own_idx == IW'(i))) begin
        bram_en    = m.m_en[i];
        bram_we    = m.m_we[4*i +: 4];
        bram_addr  = m.m_addr[AW*i +: AW];
        bram_wdata = m.m_wdata[32*i +: 32];
      end
    end
  end

  // Remember who issued a read so its data valid lands even after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d1    <= 1'b0;
      rd_owner <= '0;
    end else begin
      rd_d1    <= bram_en && (bram_we == 4'h0);
      rd_owner <= own_idx;
    end
  end

  // Steer the read-valid pulse to the master that issued the read.
  always_comb begin
    rvalid = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (rd_d1 && (rd_owner == IW'(i))) rvalid[i] = 1'b1;
    end
  end

  assign m.m_gnt    = gnt;
  assign m.m_rvalid = rvalid;
  assign m.m_rdata  = bram_rdata;
  assign bram_rst   = 1'b0;
  assign busy       = (state == OWN);
  assign owner      = 2'(own_idx);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: reset checks, table-driven contention rounds,
// hand sequences for preemption / boundary reads / reset mid-burst, and a
// randomized run checked against a behavioural ownership and memory model.
module tb_bram_port_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.N_MASTERS(N), .AW(AW)) bus ();
  bram_port_arbiter_if #(.N_MASTERS(N), .AW(AW)) bus_b ();

  logic          bram_en, bram_rst, busy;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_wdata, bram_rd;
  logic [1:0]    owner;

  logic          bram_en_b, bram_rst_b, busy_b;
  logic [3:0]    bram_we_b;
  logic [AW-1:0] bram_addr_b;
  logic [31:0]   bram_wdata_b;
  logic [1:0]    owner_b;

  bram_port_arbiter #(.N_MASTERS(N), .AW(AW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .m(bus),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rd), .bram_rst(bram_rst),
    .busy(busy), .owner(owner)
  );

  bram_port_arbiter #(.N_MASTERS(N), .AW(AW), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .m(bus_b),
    .bram_en(bram_en_b), .bram_we(bram_we_b), .bram_addr(bram_addr_b),
    .bram_wdata(bram_wdata_b), .bram_rdata(32'h0), .bram_rst(bram_rst_b),
    .busy(busy_b), .owner(owner_b)
  );

  // BRAM behavioural model: byte writes, 1-cycle registered read.
  logic [31:0] mem [0:31];
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr[6:2]][8*b +: 8] <= bram_wdata[8*b +: 8];
      if (bram_we == 4'h0) bram_rd <= mem[bram_addr[6:2]];
    end
  end

  // Stimulus per master
  logic          d_req [N];
  logic          d_en  [N];
  logic [3:0]    d_we  [N];
  logic [AW-1:0] d_addr[N];
  logic [31:0]   d_wd  [N];

  // Reference model state
  int          md_own, md_rr, md_last, md_cnt, md_rv_own;
  bit          md_rv;
  logic [31:0] md_rv_data;
  logic [31:0] ref_mem [0:31];

  int n_vec = 0;
  int n_bad = 0;
  int rv0_cnt = 0;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  en;
    logic [1:0]  gnt;
    logic        ben;
    logic [1:0]  rv;
    logic [31:0] addr;
    logic [1:0]  own;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.m_req   = {d_req[1], d_req[0]};
    bus.m_en    = {d_en[1], d_en[0]};
    bus.m_we    = {d_we[1], d_we[0]};
    bus.m_addr  = {d_addr[1], d_addr[0]};
    bus.m_wdata = {d_wd[1], d_wd[0]};
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      d_req[i] = 1'b0; d_en[i] = 1'b0; d_we[i] = 4'h0;
      d_addr[i] = '0;  d_wd[i] = 32'h0;
    end
    drive();
  endtask

  task automatic model_reset();
    md_own = -1; md_rr = N - 1; md_last = 0; md_cnt = 0;
    md_rv = 1'b0; md_rv_own = 0; md_rv_data = 32'h0;
  endtask

  // Check this cycle's outputs against the model, then advance it one edge.
  task automatic model_step();
    logic          q, e_en, others;
    logic [3:0]    e_we;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wd;
    logic [1:0]    e_gnt, e_rv;
    q = 1'b0; e_en = 1'b0; e_we = 4'h0; e_addr = '0; e_wd = 32'h0;
    e_gnt = 2'b00; e_rv = 2'b00;
    if (md_own >= 0) begin
      q = d_req[md_own];
      e_gnt[md_own] = 1'b1;
    end
    if (q) begin
      e_en = d_en[md_own]; e_we = d_we[md_own];
      e_addr = d_addr[md_own]; e_wd = d_wd[md_own];
    end
    if (md_rv) e_rv[md_rv_own] = 1'b1;
    chk("gnt", bus.m_gnt, e_gnt);
    chk("owner", owner, md_last);
    chk("busy", busy, md_own >= 0);
    chk("bram_en", bram_en, e_en);
    chk("bram_we", bram_we, e_we);
    chk("bram_addr", bram_addr, e_addr);
    chk("bram_wdata", bram_wdata, e_wd);
    chk("rvalid", bus.m_rvalid, e_rv);
    if (md_rv) chk("rdata", bus.m_rdata, md_rv_data);
    if (bus.m_rvalid[0]) rv0_cnt++;
    // memory effect of this cycle
    if (e_en && e_we != 4'h0)
      for (int b = 0; b < 4; b++)
        if (e_we[b]) ref_mem[e_addr[6:2]][8*b +: 8] = e_wd[8*b +: 8];
    md_rv = e_en && (e_we == 4'h0);
    if (md_rv) begin
      md_rv_own  = md_own;
      md_rv_data = ref_mem[e_addr[6:2]];
    end
    // ownership for the next cycle
    if (md_own < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (md_rr + k) % N;
        if (d_req[c]) begin
          md_own = c; md_last = c; md_cnt = 1;
          break;
        end
      end
    end else begin
      others = 1'b0;
      for (int j = 0; j < N; j++) if (j != md_own && d_req[j]) others = 1'b1;
      if (!d_req[md_own] || (MH != 0 && md_cnt == MH && others)) begin
        md_rr = md_own; md_own = -1;
      end else begin
        md_cnt++;
      end
    end
  endtask

  task automatic cyc();
    drive();
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          req    en     gnt    ben   rv     addr       own
    tbl[0]  = '{2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 32'h00, 2'd0};
    tbl[1]  = '{2'b11, 2'b01, 2'b01, 1'b1, 2'b00, 32'h10, 2'd0};
    tbl[2]  = '{2'b10, 2'b01, 2'b01, 1'b0, 2'b01, 32'h00, 2'd0};
    tbl[3]  = '{2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 32'h00, 2'd0};
    tbl[4]  = '{2'b11, 2'b10, 2'b10, 1'b1, 2'b00, 32'h20, 2'd1};
    tbl[5]  = '{2'b01, 2'b01, 2'b10, 1'b0, 2'b10, 32'h00, 2'd1};
    tbl[6]  = '{2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 32'h00, 2'd1};
    tbl[7]  = '{2'b11, 2'b00, 2'b01, 1'b0, 2'b00, 32'h10, 2'd0};
    tbl[8]  = '{2'b10, 2'b00, 2'b01, 1'b0, 2'b00, 32'h00, 2'd0};
    tbl[9]  = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 32'h00, 2'd0};
    tbl[10] = '{2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 32'h20, 2'd1};
    tbl[11] = '{2'b00, 2'b00, 2'b10, 1'b0, 2'b00, 32'h00, 2'd1};
    tbl[12] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 32'h00, 2'd1};

    bus_b.m_req = '0; bus_b.m_en = '0; bus_b.m_we = '0;
    bus_b.m_addr = '0; bus_b.m_wdata = '0;
    rst_n = 1'b0;
    model_reset();
    clear_inputs();
    #1;
    // reset state
    chk("rst_gnt", bus.m_gnt, 2'b00);
    chk("rst_owner", owner, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bram_en", bram_en, 1'b0);
    chk("rst_bram_we", bram_we, 4'h0);
    chk("rst_bram_addr", bram_addr, 32'h0);
    chk("rst_bram_wdata", bram_wdata, 32'h0);
    chk("rst_rvalid", bus.m_rvalid, 2'b00);
    chk("rst_bram_rst", bram_rst, 1'b0);
    d_req[0] = 1'b1; d_req[1] = 1'b1; d_en[0] = 1'b1; d_we[0] = 4'hF;
    drive();
    @(posedge clk); #1;
    chk("rst_hold_gnt", bus.m_gnt, 2'b00);
    chk("rst_hold_en", bram_en, 1'b0);
    do_reset();

    // single master: fill, write pattern, read back; m1 toggles without request
    d_req[0] = 1'b1;
    cyc();
    for (int i = 0; i < 40; i++) begin
      d_en[0] = 1'b1; d_we[0] = 4'hF;
      d_addr[0] = 32'(4 * (i % 32));
      d_wd[0] = (i < 32) ? 32'(i) * 32'h0101_0101 : 32'hA5A5_0000 + 32'(i - 32);
      d_en[1] = 1'($urandom); d_we[1] = 4'($urandom);
      d_addr[1] = 32'($urandom_range(0, 31) * 4); d_wd[1] = $urandom;
      cyc();
    end
    rv0_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      d_en[0] = 1'b1; d_we[0] = 4'h0; d_addr[0] = 32'(4 * i);
      d_en[1] = 1'($urandom); d_we[1] = 4'($urandom);
      cyc();
      chk("single_rdata", bus.m_rdata, 32'hA5A5_0000 + 32'(i));
      chk("single_rv1", bus.m_rvalid[1], 1'b0);
    end
    d_en[0] = 1'b0;
    cyc();
    chk("single_rvalid_count", 64'(rv0_cnt), 64'd8);
    clear_inputs();
    cyc(); cyc();

    // contention table after a fresh reset
    do_reset();
    d_addr[0] = 32'h10; d_addr[1] = 32'h20;
    for (int i = 0; i < 13; i++) begin
      d_req[0] = tbl[i].req[0]; d_req[1] = tbl[i].req[1];
      d_en[0]  = tbl[i].en[0];  d_en[1]  = tbl[i].en[1];
      drive(); #1;
      chk($sformatf("tbl%0d_gnt", i), bus.m_gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_en", i), bram_en, tbl[i].ben);
      chk($sformatf("tbl%0d_rv", i), bus.m_rvalid, tbl[i].rv);
      chk($sformatf("tbl%0d_addr", i), bram_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_own", i), owner, tbl[i].own);
      chk($sformatf("tbl%0d_busy", i), busy, |tbl[i].gnt);
      cyc();
    end
    clear_inputs();

    // preemption after MH owned cycles
    d_req[0] = 1'b1;
    cyc();
    for (int k = 1; k <= MH; k++) begin
      d_req[1] = (k >= 3);
      drive(); #1;
      chk($sformatf("pre_hold%0d_gnt", k), bus.m_gnt, 2'b01);
      cyc();
    end
    chk("pre_drop_gnt", bus.m_gnt, 2'b00);
    cyc();
    chk("pre_m1_gnt", bus.m_gnt, 2'b10);
    d_req[1] = 1'b0;
    cyc();
    chk("pre_m1_rel", bus.m_gnt, 2'b00);
    cyc();
    chk("pre_regrant", bus.m_gnt, 2'b01);
    d_req[0] = 1'b0;
    cyc(); cyc();

    // boundary reads around release
    d_req[0] = 1'b1;
    cyc();
    d_en[0] = 1'b1; d_we[0] = 4'h0; d_addr[0] = 32'h8;
    cyc();
    d_req[0] = 1'b0; d_addr[0] = 32'hC;
    drive(); #1;
    chk("bnd_en_masked", bram_en, 1'b0);
    chk("bnd_rvalid", bus.m_rvalid, 2'b01);
    chk("bnd_rdata", bus.m_rdata, 32'hA5A5_0002);
    cyc();
    d_en[0] = 1'b0;
    drive(); #1;
    chk("bnd_no_rv", bus.m_rvalid, 2'b00);
    cyc();
    d_req[0] = 1'b1;
    cyc();
    d_req[0] = 1'b0; d_en[0] = 1'b1;
    drive(); #1;
    chk("bnd_drop_en", bram_en, 1'b0);
    cyc();
    d_en[0] = 1'b0;
    drive(); #1;
    chk("bnd_drop_rv", bus.m_rvalid, 2'b00);
    cyc();

    // reset in the middle of an owned read burst
    d_req[0] = 1'b1;
    cyc();
    d_en[0] = 1'b1; d_we[0] = 4'h0; d_addr[0] = 32'h0;
    cyc(); cyc();
    d_we[0] = 4'hF;
    drive(); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", bus.m_gnt, 2'b00);
    chk("mid_rst_en", bram_en, 1'b0);
    chk("mid_rst_we", bram_we, 4'h0);
    chk("mid_rst_rvalid", bus.m_rvalid, 2'b00);
    chk("mid_rst_busy", busy, 1'b0);
    model_reset();
    clear_inputs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    d_req[0] = 1'b1;
    drive(); #1;
    chk("mid_rst_gnt_wait", bus.m_gnt, 2'b00);
    cyc();
    chk("mid_rst_regrant", bus.m_gnt, 2'b01);
    clear_inputs();
    cyc(); cyc();

    // MAX_HOLD=0 instance never preempts
    bus_b.m_req = 2'b01; bus_b.m_en = 2'b01;
    cyc();
    for (int k = 1; k <= 40; k++) begin
      bus_b.m_req = (k >= 3) ? 2'b11 : 2'b01;
      #1;
      chk($sformatf("nohold%0d_gnt", k), bus_b.m_gnt, 2'b01);
      chk($sformatf("nohold%0d_en", k), bram_en_b, 1'b1);
      cyc();
    end
    bus_b.m_req = 2'b00; bus_b.m_en = 2'b00;
    cyc(); cyc();

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) d_req[i] = ~d_req[i];
        d_en[i] = 1'($urandom);
        case ($urandom_range(0, 3))
          0, 1:    d_we[i] = 4'h0;
          2:       d_we[i] = 4'hF;
          default: d_we[i] = 4'($urandom);
        endcase
        d_addr[i] = {25'h0, 5'($urandom), 2'b00};
        d_wd[i] = $urandom;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
